// File: rtl/reg_file_mp.sv
// reg_file_mp: 64-entry GPR/HI-LO/CP0 register file with N read ports
// and a per-register pending scoreboard for decode-stage hazard stalls.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   wen/waddr/wdata           single-register write
//   double_en/double_wdata    HI/LO pair write, {HI, LO}
//   exception/cp0_*           CP0 STATUS/CAUSE/EPC triple write
//   raddr/rdata               packed read indices / combinational data
//   issue_en/issue_addr       mark a destination register pending
//   rd_busy/any_busy          per-port pending flag / OR of all pending
//
// Build option: RF_BYPASS_EN forwards same-cycle write data to reads.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_RD     = 2,
    parameter int HILO_BASE  = 32,
    parameter int CP0_BASE   = 44
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen,
    input  logic [ADDR_WIDTH-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       double_en,
    input  logic [2*DATA_WIDTH-1:0]    double_wdata,
    input  logic                       exception,
    input  logic [DATA_WIDTH-1:0]      cp0_status,
    input  logic [DATA_WIDTH-1:0]      cp0_cause,
    input  logic [DATA_WIDTH-1:0]      cp0_epc,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    input  logic                       issue_en,
    input  logic [ADDR_WIDTH-1:0]      issue_addr,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic                       any_busy
);

    localparam int DW    = DATA_WIDTH;
    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (ADDR_WIDTH < 6) begin : g_bad_aw
        $error("reg_file_mp: ADDR_WIDTH must be >= 6");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_nrd
        $error("reg_file_mp: NUM_RD must be 1..4");
    end
    if (CP0_BASE < 1 || CP0_BASE + 2 >= DEPTH) begin : g_bad_cp0
        $error("reg_file_mp: CP0_BASE out of range");
    end
    if (HILO_BASE < 1 || HILO_BASE + 1 >= DEPTH) begin : g_bad_hilo
        $error("reg_file_mp: HILO_BASE out of range");
    end

    logic [DW-1:0]    regs   [DEPTH];
    logic [DW-1:0]    wr_dat [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic [DEPTH-1:0] set_en;
    logic [DEPTH-1:0] pending;

    // Per-index write decode. Only one write class commits per cycle;
    // register 0 is never written or marked pending. Reset masks both so
    // the bypass path cannot leak data while rst is held.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            wr_en[j]  = 1'b0;
            wr_dat[j] = '0;
            set_en[j] = issue_en && (int'(issue_addr) == j);
            if (exception) begin
                if (j == CP0_BASE) begin
                    wr_en[j]  = 1'b1;
                    wr_dat[j] = cp0_status;
                end else if (j == CP0_BASE + 1) begin
                    wr_en[j]  = 1'b1;
                    wr_dat[j] = cp0_cause;
                end else if (j == CP0_BASE + 2) begin
                    wr_en[j]  = 1'b1;
                    wr_dat[j] = cp0_epc;
                end
            end else if (double_en) begin
                if (j == HILO_BASE) begin
                    wr_en[j]  = 1'b1;
                    wr_dat[j] = double_wdata[DW-1:0];
                end else if (j == HILO_BASE + 1) begin
                    wr_en[j]  = 1'b1;
                    wr_dat[j] = double_wdata[2*DW-1:DW];
                end
            end else if (wen && int'(waddr) == j) begin
                wr_en[j]  = 1'b1;
                wr_dat[j] = wdata;
            end
            if (j == 0 || rst) begin
                wr_en[j]  = 1'b0;
                set_en[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                regs[j] <= '0;
            end
            pending <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (wr_en[j]) begin
                    regs[j] <= wr_dat[j];
                end
            end
            // A new issue outranks the clear from a retiring write.
            pending <= set_en | (pending & ~wr_en);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = raddr[i*AW +: AW];
`ifdef RF_BYPASS_EN
        assign rdata[i*DW +: DW] = wr_en[a] ? wr_dat[a] : regs[a];
        assign rd_busy[i]        = wr_en[a] ? set_en[a] : pending[a];
`else
        assign rdata[i*DW +: DW] = regs[a];
        assign rd_busy[i]        = pending[a];
`endif
    end

    assign any_busy = |pending;

endmodule
